mux4_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one 4:1 mux output channel between four requesters.
//  - Arbitrates req[3:0] and drives the mux selects s1/s0.
//  - Gates the muxed data onto out with a valid flag.
//  - Bounds each grant to MAX_HOLD cycles so no requester can starve the others.
//  - Sits directly in front of the 4:1 mux datapath and replaces free-running select toggling.

---
 rtl/mux4_rr_scheduler_pkg.sv | 14 +
 rtl/mux4_rr_scheduler_if.sv | 35 +++
 rtl/mux4_rr_scheduler_rr_pick4.sv | 25 ++
 rtl/mux4_rr_scheduler.sv | 97 +++++++++
 tb/tb_mux4_rr_scheduler.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mux4_rr_scheduler_pkg.sv
// Shared constants, state type and helpers for the 4-channel round-robin mux scheduler.
package mux_sched_pkg;
   localparam int NCH   = 4;
   localparam int SEL_W = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } sched_state_t;

   function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] idx);
      return NCH'(1) << idx;
   endfunction
endpackage

// File: rtl/mux4_rr_scheduler_if.sv
// Requester/scheduler bundle: request and data lines in, grant, selects, gated data and debug state out.
interface mux4_rr_scheduler_if
   import mux_sched_pkg::*;
#(
   parameter int DATA_W   = 1,
   parameter int MAX_HOLD = 8
);
   localparam int HC_W = $clog2(MAX_HOLD) + 1;

   // req is level-sampled at each rising edge with no ready/ack; out carries data only
   // in cycles where out_valid is high and is all zeros otherwise.
   logic [NCH-1:0]    req;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] c;
   logic [DATA_W-1:0] d;
   logic [NCH-1:0]    gnt;
   logic              s0;
   logic              s1;
   logic [DATA_W-1:0] out;
   logic              out_valid;
   sched_state_t      state;
   logic [SEL_W-1:0]  ptr;
   logic [HC_W-1:0]   hold_cnt;

   modport master (
      output req, a, b, c, d,
      input  gnt, s0, s1, out, out_valid, state, ptr, hold_cnt
   );

   modport slave (
      input  req, a, b, c, d,
      output gnt, s0, s1, out, out_valid, state, ptr, hold_cnt
   );
endinterface

// File: rtl/mux4_rr_scheduler_rr_pick4.sv
// Combinational round-robin picker: first requesting channel at or after ptr, wrapping 3->0.
module rr_pick4
   import mux_sched_pkg::*;
(
   input  logic [NCH-1:0]   req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] winner,
   output logic             any
);
   logic [SEL_W-1:0] idx;

   // Scanning from the farthest offset down lets the nearest requester overwrite the result.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      idx    = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         idx = ptr + SEL_W'(i);
         if (req[idx]) begin
            winner = idx;
            any    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler driving a shared 4:1 mux with bounded grant hold and gated output data.
module mux4_rr_scheduler
   import mux_sched_pkg::*;
#(
   parameter int DATA_W   = 1,
   parameter int MAX_HOLD = 8
) (
   input logic                clk,
   input logic                rst_n,
   mux4_rr_scheduler_if.slave bus
);
   localparam int              HC_W      = $clog2(MAX_HOLD) + 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

   sched_state_t     state_q;
   logic [NCH-1:0]   gnt_q;
   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] ptr_q;
   logic [HC_W-1:0]  hold_q;

   logic [SEL_W-1:0] pick_ptr;
   logic [SEL_W-1:0] winner;
   logic             any;
   logic             keep;

   // While granted the picker only matters on release, when the search restarts after the owner.
   assign pick_ptr = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;
   assign keep     = bus.req[sel_q] && (hold_q < HOLD_LAST);

   rr_pick4 u_pick (
      .req    (bus.req),
      .ptr    (pick_ptr),
      .winner (winner),
      .any    (any)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any) begin
                  gnt_q   <= onehot(winner);
                  sel_q   <= winner;
                  hold_q  <= '0;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (keep) begin
                  hold_q <= hold_q + HC_W'(1);
               end else begin
                  ptr_q  <= sel_q + SEL_W'(1);
                  hold_q <= '0;
                  if (any) begin
                     gnt_q <= onehot(winner);
                     sel_q <= winner;
                  end else begin
                     gnt_q   <= '0;
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
               hold_q  <= '0;
            end
         endcase
      end
   end

   always_comb begin
      bus.out = '0;
      if (|gnt_q) begin
         case (sel_q)
            2'd0:    bus.out = bus.a;
            2'd1:    bus.out = bus.b;
            2'd2:    bus.out = bus.c;
            default: bus.out = bus.d;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.s0        = sel_q[0];
   assign bus.s1        = sel_q[1];
   assign bus.out_valid = |gnt_q;
   assign bus.state     = state_q;
   assign bus.ptr       = ptr_q;
   assign bus.hold_cnt  = hold_q;
endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Scoreboard bench: a grant-history reference model predicts every cycle, a monitor compares.
module tb_mux4_rr_scheduler;
   import mux_sched_pkg::*;

   localparam int DATA_W   = 4;
   localparam int MAX_HOLD = 4;
   localparam int HC_W     = $clog2(MAX_HOLD) + 1;
   localparam int EW       = NCH + SEL_W + SEL_W + HC_W + DATA_W;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux4_rr_scheduler_if #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) bus ();

   mux4_rr_scheduler #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0]     exp_q[$];
   int                checks   = 0;
   int                failures = 0;
   logic [DATA_W-1:0] data[NCH];

   // Reference model: who owns the channel, how many consecutive cycles it has had it,
   // where the next search starts, and the last select value.
   int m_owner = -1;
   int m_held  = 0;
   int m_ptr   = 0;
   int m_sel   = 0;

   function automatic int pick(input logic [3:0] r, input int start);
      for (int k = 0; k < NCH; k++) begin
         int ch;
         ch = (start + k) % NCH;
         if (r[ch]) return ch;
      end
      return -1;
   endfunction

   task automatic model_edge(input logic rst, input logic [3:0] r);
      int w;
      if (!rst) begin
         m_owner = -1; m_held = 0; m_ptr = 0; m_sel = 0;
      end else if (m_owner < 0) begin
         w = pick(r, m_ptr);
         if (w >= 0) begin m_owner = w; m_held = 1; m_sel = w; end
      end else if (r[m_owner] && m_held < MAX_HOLD) begin
         m_held++;
      end else begin
         m_ptr = (m_owner + 1) % NCH;
         w = pick(r, m_ptr);
         if (w >= 0) begin m_owner = w; m_held = 1; m_sel = w; end
         else begin m_owner = -1; m_held = 0; end
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic rst, input logic [3:0] r);
      logic [NCH-1:0]    e_gnt;
      logic [DATA_W-1:0] e_out;
      logic [HC_W-1:0]   e_hc;
      rst_n   = rst;
      bus.req = r;
      for (int i = 0; i < NCH; i++) data[i] = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      bus.a = data[0]; bus.b = data[1]; bus.c = data[2]; bus.d = data[3];
      model_edge(rst, r);
      e_gnt = (m_owner >= 0) ? NCH'(1 << m_owner) : '0;
      e_out = (m_owner >= 0) ? data[m_owner] : '0;
      e_hc  = (m_owner >= 0) ? HC_W'(m_held - 1) : '0;
      exp_q.push_back({e_gnt, SEL_W'(m_sel), SEL_W'(m_ptr), e_hc, e_out});
      @(negedge clk);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [EW-1:0]     e;
      logic [NCH-1:0]    e_gnt;
      logic [SEL_W-1:0]  e_sel;
      logic [SEL_W-1:0]  e_ptr;
      logic [HC_W-1:0]   e_hc;
      logic [DATA_W-1:0] e_out;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            {e_gnt, e_sel, e_ptr, e_hc, e_out} = e;
            check("gnt", int'(bus.gnt), int'(e_gnt));
            check("out_valid", int'(bus.out_valid), int'(|e_gnt));
            check("sel", int'({bus.s1, bus.s0}), int'(e_sel));
            check("out", int'(bus.out), int'(e_out));
            check("ptr", int'(bus.ptr), int'(e_ptr));
            check("state", int'(bus.state == GRANT), int'(|e_gnt));
            if (|e_gnt) check("hold_cnt", int'(bus.hold_cnt), int'(e_hc));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] cur_req;
      logic       cur_rst;
      bus.req = '0;
      bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;

      // reset with all requesting, then release: ch0 first, then full rotation with timeouts
      repeat (2) step(1'b0, 4'b1111);
      repeat (20) step(1'b1, 4'b1111);

      // single short request on ch2
      repeat (2) step(1'b1, 4'b0000);
      repeat (3) step(1'b1, 4'b0100);
      repeat (2) step(1'b1, 4'b0000);

      // lone requester regranted across timeouts
      repeat (10) step(1'b1, 4'b0010);
      repeat (2) step(1'b1, 4'b0000);

      // ch3 owns, ch0 waits, ch3 drops: immediate handover to ch0
      repeat (2) step(1'b1, 4'b1000);
      step(1'b1, 4'b1001);
      repeat (3) step(1'b1, 4'b0001);
      repeat (2) step(1'b0, 4'b0000);

      // reset in the middle of a ch1 grant
      repeat (3) step(1'b1, 4'b0010);
      step(1'b0, 4'b0010);
      repeat (3) step(1'b1, 4'b1111);

      // randomized traffic with sticky request patterns and occasional reset
      cur_req = 4'b0000;
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom_range(0, 15));
         cur_rst = ($urandom_range(0, 59) != 0);
         step(cur_rst, cur_req);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
